// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS register-file writeback block.
// Provides wb_entry_t (queued load write) and the addr_is_zero helper.
package mips_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic addr_is_zero(
    input logic [ADDR_W-1:0] a
  );
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Pending load-write queue: DEPTH-slot circular buffer with per-slot kill.
// Ports: push/pop control, kill by address, head, all slots, tail, count, full.
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     kill,
  input  logic [ADDR_W-1:0]        kill_addr,
  output wb_entry_t                head,
  output wb_entry_t                slots [DEPTH],
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] hd;

  assign head = slots[hd];
  assign full = count == CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && slots[i].addr == kill_addr) begin
          slots[i].live <= 1'b0;
        end
      end
      // A push reuses a slot, so it overrides any kill on that slot.
      if (push) begin
        slots[tail] <= push_entry;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        hd <= hd + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(pop && count == '0)
  );

endmodule

// File: rtl/regfile_writeback.sv
// Write-port master for the 32x32 register file: ALU/load merge and bypass.
// Bypass lookup is built only with `define WB_BYPASS_EN; otherwise fwd_* = 0.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_wb_pkg::DATA_W,
  parameter int ADDR_W = mips_wb_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   we3,
  output logic [ADDR_W-1:0]      A3,
  output logic [DATA_W-1:0]      WD3,
  input  logic [ADDR_W-1:0]      fwd_addr1,
  input  logic [ADDR_W-1:0]      fwd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATA_W-1:0]      fwd_data1,
  output logic [DATA_W-1:0]      fwd_data2,
  output logic [$clog2(DEPTH):0] pending_cnt,
  output logic                   idle
);
  import mips_wb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          alu_hit;
  logic          ready_en;
  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] tail;
  wb_entry_t     push_entry;
  wb_entry_t     head;
  wb_entry_t     slots [DEPTH];

  assign alu_hit   = alu_valid && !addr_is_zero(alu_addr);
  assign mem_ready = ready_en && !full;
  assign push      = mem_valid && mem_ready && !addr_is_zero(mem_addr);
  assign pop       = !alu_hit && (pending_cnt != '0);
  assign idle      = (pending_cnt == '0) && !we3;

  // Same-edge ALU write to the same register is younger than the load.
  always_comb begin
    push_entry      = '0;
    push_entry.live = !(alu_hit && mem_addr == alu_addr);
    push_entry.addr = mem_addr;
    push_entry.data = mem_data;
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .kill      (alu_hit),
    .kill_addr (alu_addr),
    .head      (head),
    .slots     (slots),
    .tail      (tail),
    .count     (pending_cnt),
    .full      (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      we3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
    end else begin
      ready_en <= 1'b1;
      unique case (1'b1)
        alu_hit: begin
          we3 <= 1'b1;
          A3  <= alu_addr;
          WD3 <= alu_data;
        end
        pop: begin
          we3 <= head.live;
          if (head.live) begin
            A3  <= head.addr;
            WD3 <= head.data;
          end
        end
        default: we3 <= 1'b0;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to newest so the youngest live match wins,
  // then let the output register and the ALU input override.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = tail - PW'(k + 1);
      if (CW'(k) < pending_cnt && slots[idx].live) begin
        if (slots[idx].addr == fwd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = slots[idx].data;
        end
        if (slots[idx].addr == fwd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = slots[idx].data;
        end
      end
    end
    if (we3 && A3 == fwd_addr1) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = WD3;
    end
    if (we3 && A3 == fwd_addr2) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = WD3;
    end
    if (alu_hit && alu_addr == fwd_addr1) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = alu_data;
    end
    if (alu_hit && alu_addr == fwd_addr2) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = alu_data;
    end
    if (addr_is_zero(fwd_addr1)) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (addr_is_zero(fwd_addr2)) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;

  logic unused_fwd;
  always_comb begin
    unused_fwd = ^{fwd_addr1, fwd_addr2, tail};
    for (int k = 0; k < DEPTH; k++) begin
      unused_fwd = unused_fwd ^ (^slots[k]);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: queue-based reference model,
// directed scenarios plus randomized ALU/load traffic.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  typedef struct {
    bit       live;
    bit [4:0] addr;
    bit [31:0] data;
  } ment_t;

  typedef struct {
    bit [4:0]  addr;
    bit [31:0] data;
  } wr_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        alu_valid = 0;
  logic [4:0]  alu_addr = 0;
  logic [31:0] alu_data = 0;
  logic        mem_valid = 0;
  logic        mem_ready;
  logic [4:0]  mem_addr = 0;
  logic [31:0] mem_data = 0;
  logic        we3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  fwd_addr1 = 0;
  logic [4:0]  fwd_addr2 = 0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  pending_cnt;
  logic        idle;

  int checks = 0;
  int errors = 0;

  ment_t mq[$];
  wr_t   sb[$];
  wr_t   src[$];
  bit        out_v = 0;
  bit [4:0]  out_a = 0;
  bit [31:0] out_d = 0;
  bit        started = 0;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .we3(we3), .A3(A3), .WD3(WD3),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .pending_cnt(pending_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

`ifdef WB_BYPASS_EN
  // Youngest value not yet in the register file for register a.
  task automatic exp_fwd(input logic [4:0] a, output logic h,
                         output logic [31:0] d);
    h = 0;
    d = 0;
    if (a != 0) begin
      foreach (mq[i]) begin
        if (mq[i].live && mq[i].addr == a) begin
          h = 1;
          d = mq[i].data;
        end
      end
      if (out_v && out_a == a) begin
        h = 1;
        d = out_d;
      end
      if (alu_valid && alu_addr == a) begin
        h = 1;
        d = alu_data;
      end
    end
  endtask
`endif

  // Advance the reference model across one rising edge.
  task automatic model_edge();
    bit acc;
    bit aq;
    ment_t e;
    acc = mem_valid && started && (mq.size() < DEPTH);
    aq  = alu_valid && (alu_addr != 0);
    if (aq) begin
      foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].live = 0;
      sb.push_back('{addr: alu_addr, data: alu_data});
      out_v = 1;
      out_a = alu_addr;
      out_d = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      out_v = e.live;
      if (e.live) begin
        sb.push_back('{addr: e.addr, data: e.data});
        out_a = e.addr;
        out_d = e.data;
      end
    end else begin
      out_v = 0;
    end
    if (acc) begin
      if (mem_addr != 0)
        mq.push_back('{live: !(aq && mem_addr == alu_addr),
                       addr: mem_addr, data: mem_data});
      void'(src.pop_front());
    end
    started = 1;
  endtask

  task automatic step(input bit av, input bit [4:0] aa, input bit [31:0] ad,
                      input bit [4:0] f1, input bit [4:0] f2, input bit moff);
    logic        h;
    logic [31:0] d;
    @(negedge clk);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = (src.size() > 0) && !moff;
    if (src.size() > 0) begin
      mem_addr = src[0].addr;
      mem_data = src[0].data;
    end else begin
      mem_addr = 5'($urandom);
      mem_data = $urandom;
    end
    fwd_addr1 = f1;
    fwd_addr2 = f2;
    #1;
    chk("mem_ready", mem_ready, 32'(started && mq.size() < DEPTH));
    chk("pending_cnt", pending_cnt, mq.size());
    chk("idle", idle, 32'(mq.size() == 0 && !out_v));
    h = 0;
    d = 0;
`ifdef WB_BYPASS_EN
    exp_fwd(f1, h, d);
`endif
    chk("fwd_hit1", fwd_hit1, 32'(h));
    chk("fwd_data1", fwd_data1, d);
    h = 0;
    d = 0;
`ifdef WB_BYPASS_EN
    exp_fwd(f2, h, d);
`endif
    chk("fwd_hit2", fwd_hit2, 32'(h));
    chk("fwd_data2", fwd_data2, d);
    model_edge();
  endtask

  task automatic idle_steps(input int n, input bit [4:0] f1);
    for (int i = 0; i < n; i++) step(0, 0, 0, f1, 5'($urandom_range(0, 7)), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    alu_valid = 0;
    mem_valid = 0;
    mq.delete();
    sb.delete();
    src.delete();
    out_v = 0;
    started = 0;
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_A3", A3, 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_cnt", pending_cnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", mem_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_ready", mem_ready, 0);
    chk("rel_we3", we3, 0);
    @(posedge clk);
    started = 1;
  endtask

  // Monitor: every we3 must match the oldest expected write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (we3) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_write: got A3=%0d WD3=%h expected none",
                   A3, WD3);
        end else begin
          w = sb.pop_front();
          if (A3 !== w.addr || WD3 !== w.data) begin
            errors++;
            $display("FAIL write: got A3=%0d WD3=%h expected A3=%0d WD3=%h",
                     A3, WD3, w.addr, w.data);
          end
        end
      end else if (sb.size() != 0) begin
        checks++;
        errors++;
        w = sb.pop_front();
        $display("FAIL missing_write: got we3=0 expected A3=%0d WD3=%h",
                 w.addr, w.data);
      end
    end
  end

  initial begin
    do_reset();

    // ALU only
    step(1, 8, 32'hDEADBEEF, 8, 0, 0);
    step(0, 0, 0, 8, 0, 0);
    idle_steps(2, 8);

    // ALU and load on the same edge
    src.push_back('{addr: 10, data: 32'hA5A5_0010});
    step(1, 9, 32'h0000_9999, 10, 9, 0);
    idle_steps(3, 10);

    // WAW: load killed by same-edge ALU write to the same register
    src.push_back('{addr: 4, data: 32'h11});
    step(1, 4, 32'h22, 4, 4, 0);
    idle_steps(3, 4);

    // Backpressure under a continuous ALU stream
    for (int i = 0; i < 5; i++)
      src.push_back('{addr: 5'(11 + i), data: 32'hB000_0000 + i});
    for (int i = 0; i < 8; i++)
      step(1, 5'(20 + (i % 4)), 32'hC000_0000 + i, 11, 15, 0);
    chk("bp_waiting_load", src.size(), 1);
    idle_steps(8, 13);

    // Writes to $0
    src.push_back('{addr: 0, data: 32'h77});
    step(1, 0, 32'h55, 0, 0, 0);
    chk("zero_load_acked", src.size(), 0);
    idle_steps(2, 0);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++)
      src.push_back('{addr: 5'(3 + i), data: 32'hD000_0000 + i});
    step(1, 6, 32'h66, 3, 6, 0);
    step(1, 7, 32'h77, 4, 7, 0);
    do_reset();
    idle_steps(3, 3);

    // Randomized traffic over a small register range
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 3 && $urandom_range(0, 2) != 0)
        src.push_back('{addr: 5'($urandom_range(0, 7)), data: $urandom});
      step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0);
    end
    idle_steps(12, 1);
    chk("final_queue_empty", pending_cnt, 0);
    chk("final_idle", idle, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
